// File: rtl/evo_circuit_tester.sv
// Exhaustive test sequencer for one evolved 4-input combinational circuit.
// Drives each input vector, waits for settling, samples repeatedly, and grades against a truth table.
module evo_circuit_tester #(
    parameter int NUM_INPUTS    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int NUM_SAMPLES   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         start_i,
    input  logic [(1<<NUM_INPUTS)-1:0]   expected_i,
    output logic [NUM_INPUTS-1:0]        dut_in_o,
    input  logic                         dut_out_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [(1<<NUM_INPUTS)-1:0]   mismatch_o,
    output logic [(1<<NUM_INPUTS)-1:0]   unstable_o,
    output logic [NUM_INPUTS:0]          score_o,
    output logic                         pass_o
);

    localparam int NV   = 1 << NUM_INPUTS;
    localparam int VW   = NUM_INPUTS;
    localparam int SW   = NUM_INPUTS + 1;
    localparam int CMAX = (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [VW-1:0] LAST_VEC   = '1;
    localparam logic [SW-1:0] FULL_SCORE = SW'(NV);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, EVAL} state_t;

    state_t          state_q, state_d;
    logic [NV-1:0]   expected_q, expected_d;
    logic [NV-1:0]   mismatch_q, mismatch_d;
    logic [NV-1:0]   unstable_q, unstable_d;
    logic [SW-1:0]   score_q, score_d;
    logic            pass_q, pass_d;
    logic            done_q, done_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [VW-1:0]   dut_in_q, dut_in_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ref_q, ref_d;
    logic            stable_q, stable_d;
    logic            sync1_q, sync2_q;
    logic            evalFail;

    assign evalFail = !stable_q || (ref_q != expected_q[vec_q]);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            expected_q <= '0;
            mismatch_q <= '0;
            unstable_q <= '0;
            score_q    <= '0;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
            vec_q      <= '0;
            dut_in_q   <= '0;
            cnt_q      <= '0;
            ref_q      <= 1'b0;
            stable_q   <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            mismatch_q <= mismatch_d;
            unstable_q <= unstable_d;
            score_q    <= score_d;
            pass_q     <= pass_d;
            done_q     <= done_d;
            vec_q      <= vec_d;
            dut_in_q   <= dut_in_d;
            cnt_q      <= cnt_d;
            ref_q      <= ref_d;
            stable_q   <= stable_d;
            sync1_q    <= dut_out_i;
            sync2_q    <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = APPLY;
            APPLY:   state_d = SETTLE;
            SETTLE:  if (cnt_q == '0) state_d = SAMPLE;
            SAMPLE:  if (cnt_q == '0) state_d = EVAL;
            EVAL:    state_d = (vec_q == LAST_VEC) ? IDLE : APPLY;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        expected_d = expected_q;
        mismatch_d = mismatch_q;
        unstable_d = unstable_q;
        score_d    = score_q;
        pass_d     = pass_q;
        done_d     = 1'b0;
        vec_d      = vec_q;
        dut_in_d   = dut_in_q;
        cnt_d      = cnt_q;
        ref_d      = ref_q;
        stable_d   = stable_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    expected_d = expected_i;
                    mismatch_d = '0;
                    unstable_d = '0;
                    score_d    = '0;
                    pass_d     = 1'b0;
                    vec_d      = '0;
                end
            end
            APPLY: begin
                dut_in_d = vec_q;
                cnt_d    = CW'(SETTLE_CYCLES - 1);
            end
            SETTLE: begin
                cnt_d = (cnt_q == '0) ? CW'(NUM_SAMPLES - 1) : cnt_q - CW'(1);
            end
            SAMPLE: begin
                // The first sample becomes the reference; later ones only detect disagreement.
                if (cnt_q == CW'(NUM_SAMPLES - 1)) begin
                    ref_d    = sync2_q;
                    stable_d = 1'b1;
                end else if (sync2_q != ref_q) begin
                    stable_d = 1'b0;
                end
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            EVAL: begin
                if (evalFail) begin
                    mismatch_d[vec_q] = 1'b1;
                    unstable_d[vec_q] = !stable_q;
                end else begin
                    score_d = score_q + SW'(1);
                end
                if (vec_q == LAST_VEC) begin
                    done_d = 1'b1;
                    pass_d = (score_d == FULL_SCORE);
                end else begin
                    vec_d = vec_q + VW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
    end

    assign dut_in_o   = dut_in_q;
    assign done_o     = done_q;
    assign mismatch_o = mismatch_q;
    assign unstable_o = unstable_q;
    assign score_o    = score_q;
    assign pass_o     = pass_q;

endmodule

// File: doc/evo_circuit_tester.md
# evo_circuit_tester

Sequencer that exhaustively tests one evolved combinational circuit (a 4-input, 1-output LCELL netlist, possibly containing feedback loops). It drives every input vector onto the circuit under test in order, waits a settle window, and samples the output repeatedly to catch oscillation. It then compares the result against a target truth table and reports per-vector mismatch, per-vector instability and a fitness score. It sits between the evolution host logic and the circuit-under-test instance.

## Interface

Parameters:
- NUM_INPUTS, 4: circuit input width; vectors tested = 2^NUM_INPUTS.
- SETTLE_CYCLES, 8: cycles between applying a vector and first sample; must be ≥ 2 (covers the output synchronizer).
- NUM_SAMPLES, 4: consecutive samples taken per vector; must be ≥ 1.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a run; sampled only in IDLE.
- expected  in  2^NUM_INPUTS  target truth table; bit v = required output for vector v; latched on accepted start.
- dut_in  out  NUM_INPUTS  vector driven to circuit under test.
- dut_out  in  1  circuit output; asynchronous, passed through a 2-flop synchronizer inside this block.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- mismatch  out  2^NUM_INPUTS  bit v set if vector v failed (wrong value or unstable).
- unstable  out  2^NUM_INPUTS  bit v set if samples for vector v disagreed.
- score  out  NUM_INPUTS+1  count of passing vectors, 0..2^NUM_INPUTS.
- pass  out  1  score == 2^NUM_INPUTS.

## Operation

- States: IDLE, APPLY, SETTLE, SAMPLE, EVAL.
- IDLE: busy=0. If start=1: latch expected, clear mismatch/unstable/score/pass, vector index v=0 -> APPLY.
- APPLY (1 cycle): dut_in <= v -> SETTLE.
- SETTLE (SETTLE_CYCLES cycles, down-counter) -> SAMPLE.
- SAMPLE (NUM_SAMPLES cycles): first sample stored as ref; any later sample ≠ ref sets stable-flag false.
- EVAL (1 cycle): vector fails if unstable or ref ≠ expected[v]. Set unstable[v]/mismatch[v] accordingly. Otherwise score += 1. If v == 2^NUM_INPUTS−1: done=1, pass updated, -> IDLE. Else v += 1 -> APPLY.
- dut_in holds the last vector after a run; it returns to 0 only on reset.
- start while busy: ignored. start held high: a new run is accepted on the first IDLE cycle after done.
- Results (mismatch, unstable, score, pass) hold from done until the next accepted start or reset.
- Synchronizer flops are reset to 0 and run continuously in every state.

## Timing

- Reset (rst_n=0 at a clk edge): state IDLE; dut_in=0, busy=0, done=0, mismatch=0, unstable=0, score=0, pass=0, synchronizer=0. Reset mid-run aborts immediately with no done pulse.
- start sampled high at edge T: busy=1 from T+1. dut_in=0 is driven from T+2 (after APPLY).
- Per vector: 1 + SETTLE_CYCLES + NUM_SAMPLES + 1 cycles.
- done is high for exactly one cycle, at cycle T+1+2^NUM_INPUTS·(SETTLE_CYCLES+NUM_SAMPLES+2), and busy is low in that same cycle. With defaults, done arrives 225 cycles after start.
- Samples use the synchronized signal. The effective settle time seen by the circuit is SETTLE_CYCLES−2 cycles plus synchronizer latency.
- score saturates by construction; it never exceeds 2^NUM_INPUTS.

## Test plan

- Circuit model = XOR of 4 inputs, expected=16'h6996 -> done at 225 cycles after start, score=16, pass=1, mismatch=0, unstable=0.
- Same model, expected=16'h6997 -> mismatch=16'h0001, unstable=0, score=15, pass=0.
- Model output toggles every cycle when dut_in=5, otherwise XOR, expected=16'h6996 -> unstable=16'h0020, mismatch=16'h0020, score=15.
- Pulse start again at vector 7 of a run -> ignored; the run completes normally with a single done pulse. Then hold start high -> second run begins the cycle after done, and results are cleared at acceptance.
- Drop rst_n for 1 cycle at vector 9 -> all outputs 0 next cycle, no done pulse, dut_in=0. A fresh start afterwards gives full correct results.
- SETTLE_CYCLES=2, NUM_SAMPLES=1, constant-1 model, expected=16'hFFFF -> done at T+1+16·5 = T+81, score=16, pass=1.
